alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL provide parameter FIRST_PRIO, default 0, meaning the requester (0 or 1) that wins the first simultaneous request after reset.
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide ports req0_valid/req1_valid  input  1  requester has an operation pending.
REQ-005 SHALL provide ports req0_ready/req1_ready  output  1  operation accepted this cycle.
REQ-006 SHALL provide ports req0_a, req0_b, req1_a, req1_b  input  32  operands.
REQ-007 SHALL provide ports req0_sel/req1_sel  input  4  ALU opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1111 EQ, others ADD.
REQ-008 SHALL provide ports alu_a, alu_b  output  32, and alu_sel  output  4, all driving the shared ALU.
REQ-009 SHALL provide ports alu_out  input  32, and alu_cf, alu_ov, alu_zero  input  1, all returned by the shared ALU.
REQ-010 SHALL provide port rsp_valid  output  1  result available.
REQ-011 SHALL provide port rsp_ready  input  1  consumer accepts the result.
REQ-012 SHALL provide port rsp_id  output  1  index of the requester that owns the result.
REQ-013 SHALL provide port rsp_result  output  32, and rsp_cf, rsp_ov, rsp_zero  output  1, all captured from the ALU.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, EXEC and RESP.
REQ-015 In IDLE, if either valid is high, SHALL grant exactly one requester, assert only that requester's ready (combinational, same cycle), latch its a/b/sel and id, and move to EXEC.
REQ-016 In IDLE with no valid, SHALL stay in IDLE with both readies low.
REQ-017 Arbitration SHALL be round-robin: if both are valid, grant the requester not granted last; after reset, "last" is !FIRST_PRIO.
REQ-018 If one requester is valid, SHALL grant it regardless of priority, and the last-grant pointer SHALL update to that requester.
REQ-019 SHALL drive alu_a/alu_b/alu_sel from the latched registers at all times; they change only on accept.
REQ-020 In EXEC, SHALL capture alu_out/alu_cf/alu_ov/alu_zero into the rsp_* registers at the end of the cycle, unmodified, and move to RESP.
REQ-021 In RESP, SHALL hold rsp_valid high with all rsp_* stable until rsp_ready is high, then return to IDLE with rsp_valid low next cycle.
REQ-022 Latency SHALL be: accept in cycle T, rsp_valid high in T+2; minimum spacing between accepts is 3 cycles.
REQ-023 Readies SHALL be low in EXEC and RESP; requests arriving then wait (valid held by requester).
REQ-024 SHALL not alter, decode or validate sel; unsupported codes pass through to the ALU.
REQ-025 A change of requester operands after accept SHALL not affect the in-flight operation.

Reset
REQ-026 With rst high at a clock edge, SHALL enter IDLE and clear rsp_valid, rsp_id, rsp_result, rsp_cf, rsp_ov, rsp_zero, alu_a, alu_b and alu_sel to 0, and set last-grant to !FIRST_PRIO.
REQ-027 While rst is high, SHALL hold req0_ready and req1_ready low.
REQ-028 Reset in EXEC or RESP SHALL discard the in-flight operation; no rsp_valid pulse is produced for it.

Verification
REQ-029 Lone req0: ADD, a=7, b=5, with a behavioral ALU -> req0_ready high in cycle 0; rsp_valid high in cycle 2 with rsp_result=12, rsp_id=0, rsp_zero=0.
REQ-030 Both requesters valid together after reset (FIRST_PRIO=0): req0 SUB 5-5, req1 AND 0xF0&0x0F -> req0 served first (result 0, zero=1, id 0), then req1 (result 0, id 1); req1_ready asserts 3 cycles after req0_ready.
REQ-031 Both valid continuously, rsp_ready tied high -> grants alternate 0,1,0,1 across 4 operations.
REQ-032 rsp_ready held low 4 cycles in RESP -> rsp_* stable throughout and both readies low; result retired on the cycle rsp_ready rises.
REQ-033 Bench ALU forces alu_out=0, cf=1, ov=1, zero=1 only during EXEC -> rsp fields are 0/1/1/1; ALU input changes in RESP are not reflected.
REQ-034 rst pulsed during EXEC -> no rsp_valid, and all outputs are 0 next cycle; a subsequent req1-only request is served normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters; accept in IDLE, result valid two cycles later.
// Readies are low outside IDLE, so waiting requesters hold their valid; the result is held until rsp_ready.
module alu_arbiter #(
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req0_sel,
  input  logic [3:0]  req1_sel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_out,
  input  logic        alu_cf,
  input  logic        alu_ov,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_cf,
  output logic        rsp_ov,
  output logic        rsp_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_id;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [3:0]  r_alu_sel;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [31:0] r_rsp_result;
  logic        r_rsp_cf;
  logic        r_rsp_ov;
  logic        r_rsp_zero;

  logic w_idle;
  logic w_any;
  logic w_gnt1;

  assign w_idle = (r_state == IDLE) && !rst;
  assign w_any  = req0_valid || req1_valid;
  // With both pending, requester 1 wins only if requester 0 was granted last.
  assign w_gnt1 = req1_valid && (!req0_valid || !r_last);

  assign req0_ready = w_idle && req0_valid && !w_gnt1;
  assign req1_ready = w_idle && w_gnt1;

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_cf     = r_rsp_cf;
  assign rsp_ov     = r_rsp_ov;
  assign rsp_zero   = r_rsp_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last       <= ~FIRST_PRIO;
      r_id         <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sel    <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_cf     <= 1'b0;
      r_rsp_ov     <= 1'b0;
      r_rsp_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_alu_a   <= w_gnt1 ? req1_a   : req0_a;
            r_alu_b   <= w_gnt1 ? req1_b   : req0_b;
            r_alu_sel <= w_gnt1 ? req1_sel : req0_sel;
            r_id      <= w_gnt1;
            r_last    <= w_gnt1;
            r_state   <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_result <= alu_out;
          r_rsp_cf     <= alu_cf;
          r_rsp_ov     <= alu_ov;
          r_rsp_zero   <= alu_zero;
          r_rsp_id     <= r_id;
          r_rsp_valid  <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: stimulus pushes expected responses, a negedge monitor compares everything.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_sel, req1_sel;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic        alu_cf, alu_ov, alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_cf, rsp_ov, rsp_zero;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic        cf;
    logic        ov;
    logic        z;
  } rsp_t;

  rsp_t sb[$];

  logic [1:0]  exp_rdy;
  logic        exp_vld;
  logic        chk_zero;
  logic        chk_alu;
  logic [31:0] exp_a, exp_b;
  logic [3:0]  exp_sel;
  logic        done;
  logic        alu_force, alu_junk;
  int          n_vec, n_bad, n_cyc;

  alu_arbiter #(.FIRST_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_sel(req0_sel), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_cf(alu_cf), .alu_ov(alu_ov), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_cf(rsp_cf), .rsp_ov(rsp_ov), .rsp_zero(rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioral shared ALU, with overrides for the capture-timing test.
  logic [32:0] w_sum;
  always_comb begin
    w_sum    = {1'b0, alu_a} + {1'b0, alu_b};
    alu_out  = w_sum[31:0];
    alu_cf   = w_sum[32];
    alu_ov   = (alu_a[31] == alu_b[31]) && (w_sum[31] != alu_a[31]);
    case (alu_sel)
      4'b0000: begin alu_out = alu_a & alu_b; alu_cf = 1'b0; alu_ov = 1'b0; end
      4'b0001: begin alu_out = alu_a | alu_b; alu_cf = 1'b0; alu_ov = 1'b0; end
      4'b0110: begin
        alu_out = alu_a - alu_b;
        alu_cf  = alu_a < alu_b;
        alu_ov  = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      4'b0111: begin alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)}; alu_cf = 1'b0; alu_ov = 1'b0; end
      4'b1100: begin alu_out = ~(alu_a | alu_b); alu_cf = 1'b0; alu_ov = 1'b0; end
      4'b1111: begin alu_out = {31'b0, alu_a == alu_b}; alu_cf = 1'b0; alu_ov = 1'b0; end
      default: ;
    endcase
    alu_zero = (alu_out == 32'd0);
    if (alu_force) begin
      alu_out = 32'd0; alu_cf = 1'b1; alu_ov = 1'b1; alu_zero = 1'b1;
    end else if (alu_junk) begin
      alu_out = 32'hDEADBEEF; alu_cf = 1'b0; alu_ov = 1'b0; alu_zero = 1'b0;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, n_cyc);
    end
  endtask

  // Monitor: owns all comparisons and the summary.
  initial begin
    rsp_t e;
    n_vec = 0; n_bad = 0; n_cyc = 0;
    forever begin
      @(negedge clk);
      n_cyc++;
      cmp("readies", {30'b0, req1_ready, req0_ready}, {30'b0, exp_rdy});
      cmp("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_vld});
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_rsp: got result %0h with empty scoreboard", rsp_result);
        end else begin
          e = sb[0];
          cmp("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
          cmp("rsp_result", rsp_result, e.res);
          cmp("rsp_flags", {29'b0, rsp_cf, rsp_ov, rsp_zero}, {29'b0, e.cf, e.ov, e.z});
          if (rsp_ready) void'(sb.pop_front());
        end
      end
      if (chk_zero) begin
        cmp("zero_alu_a", alu_a, 32'd0);
        cmp("zero_alu_b", alu_b, 32'd0);
        cmp("zero_alu_sel", {28'b0, alu_sel}, 32'd0);
        cmp("zero_rsp_result", rsp_result, 32'd0);
        cmp("zero_rsp_bits", {28'b0, rsp_id, rsp_cf, rsp_ov, rsp_zero}, 32'd0);
      end
      if (chk_alu) begin
        cmp("alu_a", alu_a, exp_a);
        cmp("alu_b", alu_b, exp_b);
        cmp("alu_sel", {28'b0, alu_sel}, {28'b0, exp_sel});
      end
      if (done || n_cyc > 2000) begin
        if (!done) begin
          n_vec++; n_bad++;
          $display("FAIL timeout: got %0d cycles limit 2000", n_cyc);
        end
        cmp("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
      end
    end
  end

  task automatic cyc(input logic [1:0] r, input logic v);
    exp_rdy = r;
    exp_vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic id, input logic [31:0] r, input logic cf, input logic ov, input logic z);
    rsp_t e;
    e.id = id; e.res = r; e.cf = cf; e.ov = ov; e.z = z;
    sb.push_back(e);
  endtask

  task automatic set0(input logic v, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_sel = s; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_sel = s; req1_a = a; req1_b = b;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b1; done = 1'b0;
    exp_rdy = 2'b00; exp_vld = 1'b0; chk_zero = 1'b1; chk_alu = 1'b0;
    exp_a = '0; exp_b = '0; exp_sel = '0; alu_force = 1'b0; alu_junk = 1'b0;
    set0(1'b1, 4'b0010, 32'd1, 32'd2);
    set1(1'b1, 4'b0010, 32'd3, 32'd4);
    @(posedge clk); #1;
    // Reset: readies low even with both valid, outputs cleared
    cyc(2'b00, 1'b0);
    cyc(2'b00, 1'b0);
    rst = 1'b0; chk_zero = 1'b0;

    // Simultaneous after reset: req0 first, req1 three cycles later
    set0(1'b1, 4'b0110, 32'd5, 32'd5);
    set1(1'b1, 4'b0000, 32'hF0, 32'h0F);
    push(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    push(1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
    cyc(2'b01, 1'b0);
    req0_valid = 1'b0;
    cyc(2'b00, 1'b0);
    cyc(2'b00, 1'b1);
    cyc(2'b10, 1'b0);
    req1_valid = 1'b0;
    cyc(2'b00, 1'b0);
    cyc(2'b00, 1'b1);

    // Both valid continuously: grants alternate 0,1,0,1
    set0(1'b1, 4'b0001, 32'h0F, 32'hF0);
    set1(1'b1, 4'b0010, 32'hFFFFFFFF, 32'd1);
    push(1'b0, 32'hFF, 1'b0, 1'b0, 1'b0);
    push(1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
    push(1'b0, 32'hFF, 1'b0, 1'b0, 1'b0);
    push(1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 1'b0); cyc(2'b00, 1'b0); cyc(2'b00, 1'b1);
    cyc(2'b10, 1'b0);
    set1(1'b1, 4'b0111, 32'hFFFFFFFF, 32'd1);
    cyc(2'b00, 1'b0); cyc(2'b00, 1'b1);
    cyc(2'b01, 1'b0); cyc(2'b00, 1'b0); cyc(2'b00, 1'b1);
    cyc(2'b10, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc(2'b00, 1'b0); cyc(2'b00, 1'b1);

    // Lone req0 ADD 7+5; operands changed after accept
    set0(1'b1, 4'b0010, 32'd7, 32'd5);
    push(1'b0, 32'd12, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 1'b0);
    set0(1'b0, 4'b0000, 32'd99, 32'd99);
    chk_alu = 1'b1; exp_a = 32'd7; exp_b = 32'd5; exp_sel = 4'b0010;
    cyc(2'b00, 1'b0);
    chk_alu = 1'b0;
    cyc(2'b00, 1'b1);

    // rsp_ready held low 4 cycles; req0 waits meanwhile
    set1(1'b1, 4'b0010, 32'd3, 32'd4);
    push(1'b1, 32'd7, 1'b0, 1'b0, 1'b0);
    push(1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    rsp_ready = 1'b0;
    cyc(2'b10, 1'b0);
    req1_valid = 1'b0;
    set0(1'b1, 4'b1100, 32'd0, 32'd0);
    cyc(2'b00, 1'b0);
    for (int i = 0; i < 4; i++) cyc(2'b00, 1'b1);
    rsp_ready = 1'b1;
    cyc(2'b00, 1'b1);
    cyc(2'b01, 1'b0);
    req0_valid = 1'b0;
    cyc(2'b00, 1'b0); cyc(2'b00, 1'b1);

    // ALU forced only during EXEC; unsupported sel passes through
    set0(1'b1, 4'b1010, 32'd1, 32'd1);
    push(1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
    cyc(2'b01, 1'b0);
    req0_valid = 1'b0; alu_force = 1'b1;
    chk_alu = 1'b1; exp_a = 32'd1; exp_b = 32'd1; exp_sel = 4'b1010;
    cyc(2'b00, 1'b0);
    chk_alu = 1'b0; alu_force = 1'b0; alu_junk = 1'b1; rsp_ready = 1'b0;
    cyc(2'b00, 1'b1);
    rsp_ready = 1'b1;
    cyc(2'b00, 1'b1);
    alu_junk = 1'b0;

    // Reset during EXEC discards the operation; req1 then served normally
    set0(1'b1, 4'b0010, 32'd2, 32'd2);
    cyc(2'b01, 1'b0);
    req0_valid = 1'b0;
    rst = 1'b1;
    set1(1'b1, 4'b0110, 32'd10, 32'd3);
    cyc(2'b00, 1'b0);
    rst = 1'b0; chk_zero = 1'b1;
    push(1'b1, 32'd7, 1'b0, 1'b0, 1'b0);
    cyc(2'b10, 1'b0);
    chk_zero = 1'b0; req1_valid = 1'b0;
    cyc(2'b00, 1'b0);
    cyc(2'b00, 1'b1);
    cyc(2'b00, 1'b0);
    done = 1'b1;
  end

endmodule
